// File: rtl/param_stack_pkg.sv
// Shared definitions for the parametrised LIFO stack.
//   stack_op_e     : the single operation selected on each clock edge
//   stack_cw       : count width needed to hold 0..depth
//   stack_status_t : flag bundle for controllers that group status bits
//   decode_op      : priority decode of push/pop/flush into one operation
package stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_FLUSH
  } stack_op_e;

  typedef struct packed {
    logic full;
    logic empty;
    logic ovf;
    logic udf;
  } stack_status_t;

  // The count must represent DEPTH itself, hence depth+1 values.
  function automatic int stack_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Flush wins over everything; push+pop on a non-empty stack is a replace,
  // on an empty stack it degenerates to a plain push. Refusals (push when
  // full, pop when empty) are resolved by the caller from OP_PUSH/OP_POP.
  function automatic stack_op_e decode_op(input logic push, input logic pop,
                                          input logic flush, input logic nonempty);
    if (flush)                      return OP_FLUSH;
    else if (push && pop && nonempty) return OP_REPLACE;
    else if (push)                  return OP_PUSH;
    else if (pop)                   return OP_POP;
    else                            return OP_NOP;
  endfunction

endpackage

// File: rtl/param_stack_if.sv
// Command/status bundle of the stack.
//   push/pop/flush/din         : operation request for the next clock edge
//   top/count/full/empty       : current stack state (zero latency)
//   ovf/udf                    : one-cycle pulses after a refused push/pop
// Handshake: there is no valid/ready; every clock edge performs exactly one
// operation chosen from push/pop/flush, and refusals are reported by the
// ovf/udf pulses rather than by back-pressure.
interface param_stack_if import stack_pkg::*; #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 256
);
  localparam int CW = stack_cw(DEPTH);

  logic             push;
  logic             pop;
  logic             flush;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             udf;

  modport master (
    output push, pop, flush, din,
    input  top, count, full, empty, ovf, udf
  );

  modport slave (
    input  push, pop, flush, din,
    output top, count, full, empty, ovf, udf
  );

endinterface

// File: rtl/param_stack_mem.sv
// Storage array for the stack: WIDTH x DEPTH, one synchronous write port
// and one asynchronous read port. Contents are not reset.
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write address (always < DEPTH)
//   wdata : write data
//   raddr : read address (always < DEPTH)
//   rdata : combinational read data
module stack_mem #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO stack with replace-top, flush, occupancy count and
// one-cycle overflow/underflow pulses. Entry count-1 is the top.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (count=0, flags cleared)
//   bus  : param_stack_if slave (push/pop/flush/din in; top/count/full/
//          empty/ovf/udf out)
module param_stack import stack_pkg::*; #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  param_stack_if.slave  bus
);

  localparam int CW = stack_cw(DEPTH);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             full, empty;
  stack_op_e        op;
  stack_status_t    status;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign op    = decode_op(bus.push, bus.pop, bus.flush, !empty);

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    we      = 1'b0;
    waddr   = AW'(count_q);
    unique case (op)
      OP_FLUSH: count_d = '0;
      OP_REPLACE: begin
        we    = 1'b1;
        waddr = AW'(count_q - CW'(1));
      end
      OP_PUSH: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          we      = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      OP_POP: begin
        if (empty) udf_d = 1'b1;
        else       count_d = count_q - CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Read address is only meaningful when non-empty; top is forced to 0
  // otherwise so unwritten (X) memory never reaches the output.
  assign raddr = empty ? '0 : AW'(count_q - CW'(1));

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we && !rst),
    .waddr (waddr),
    .wdata (bus.din),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign status = '{full: full, empty: empty, ovf: ovf_q, udf: udf_q};

  assign bus.top   = empty ? '0 : rdata;
  assign bus.count = count_q;
  assign bus.full  = status.full;
  assign bus.empty = status.empty;
  assign bus.ovf   = status.ovf;
  assign bus.udf   = status.udf;

endmodule

// File: tb/tb_param_stack.sv
// Bench for param_stack: one DEPTH=4/WIDTH=2 instance and one DEPTH=5/WIDTH=8
// instance, each checked against a queue-based LIFO model.
module tb_param_stack;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4 = 1'b1;
  logic rst5 = 1'b1;

  param_stack_if #(.WIDTH(2), .DEPTH(4)) b4 ();
  param_stack_if #(.WIDTH(8), .DEPTH(5)) b5 ();

  param_stack #(.WIDTH(2), .DEPTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(b4.slave));
  param_stack #(.WIDTH(8), .DEPTH(5)) dut5 (.clk(clk), .rst(rst5), .bus(b5.slave));

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference models ----------------
  logic [1:0] m4[$];
  logic [7:0] m5[$];
  logic e4_ovf = 1'b0, e4_udf = 1'b0;
  logic e5_ovf = 1'b0, e5_udf = 1'b0;

  // observed {count, top, full, empty, ovf, udf}
  function automatic logic [8:0] got4();
    return {b4.count, b4.top, b4.full, b4.empty, b4.ovf, b4.udf};
  endfunction
  function automatic logic [14:0] got5();
    return {b5.count, b5.top, b5.full, b5.empty, b5.ovf, b5.udf};
  endfunction

  function automatic logic [8:0] exp4();
    logic [1:0] t;
    t = (m4.size() > 0) ? m4[$] : 2'd0;
    return {3'(m4.size()), t, m4.size() == 4, m4.size() == 0, e4_ovf, e4_udf};
  endfunction
  function automatic logic [14:0] exp5();
    logic [7:0] t;
    t = (m5.size() > 0) ? m5[$] : 8'd0;
    return {3'(m5.size()), t, m5.size() == 5, m5.size() == 0, e5_ovf, e5_udf};
  endfunction

  // ---------------- drivers ----------------
  // Each call performs one clock edge on its instance, updates the model,
  // and returns 1 time unit after the edge with the inputs back at idle.
  task automatic drive4(input logic r, input logic p, input logic q,
                        input logic f, input logic [1:0] d);
    @(negedge clk);
    rst4 = r; b4.push = p; b4.pop = q; b4.flush = f; b4.din = d;
    @(posedge clk);
    e4_ovf = 1'b0; e4_udf = 1'b0;
    if (r || f) m4.delete();
    else if (p && q && m4.size() > 0) m4[m4.size()-1] = d;
    else if (p) begin
      if (m4.size() < 4) m4.push_back(d); else e4_ovf = 1'b1;
    end else if (q) begin
      if (m4.size() > 0) void'(m4.pop_back()); else e4_udf = 1'b1;
    end
    #1;
    rst4 = 1'b0; b4.push = 1'b0; b4.pop = 1'b0; b4.flush = 1'b0;
  endtask

  task automatic drive5(input logic r, input logic p, input logic q,
                        input logic f, input logic [7:0] d);
    @(negedge clk);
    rst5 = r; b5.push = p; b5.pop = q; b5.flush = f; b5.din = d;
    @(posedge clk);
    e5_ovf = 1'b0; e5_udf = 1'b0;
    if (r || f) m5.delete();
    else if (p && q && m5.size() > 0) m5[m5.size()-1] = d;
    else if (p) begin
      if (m5.size() < 5) m5.push_back(d); else e5_ovf = 1'b1;
    end else if (q) begin
      if (m5.size() > 0) void'(m5.pop_back()); else e5_udf = 1'b1;
    end
    #1;
    rst5 = 1'b0; b5.push = 1'b0; b5.pop = 1'b0; b5.flush = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive4(1, 1, 0, 0, 2'd3);
    drive5(1, 1, 0, 0, 8'h11);
    for (int i = 0; i < 3; i++) begin
      drive4(0, 0, 0, 0, 2'd0);
      n_cmp++;
      if (got4() !== 9'b000_00_0100) begin
        n_err++; $display("FAIL reset4 idle %0d: got %h expected %h", i, got4(), 9'b000_00_0100);
      end
      drive5(0, 0, 0, 0, 8'd0);
      n_cmp++;
      if (got5() !== 15'b000_00000000_0100) begin
        n_err++; $display("FAIL reset5 idle %0d: got %h expected %h", i, got5(), 15'b000_00000000_0100);
      end
    end
  endtask

  task automatic test_push_pop();
    logic [1:0] vals [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
    drive4(1, 0, 0, 0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      drive4(0, 1, 0, 0, vals[i]);
      n_cmp++;
      if (got4() !== exp4()) begin
        n_err++; $display("FAIL push %0d: got %h expected %h", i, got4(), exp4());
      end
    end
    drive4(0, 0, 0, 0, 2'd0);  // ovf pulse must drop
    n_cmp++;
    if (got4() !== exp4()) begin
      n_err++; $display("FAIL ovf_drop: got %h expected %h", got4(), exp4());
    end
    for (int i = 0; i < 5; i++) begin
      drive4(0, 0, 1, 0, 2'd0);
      n_cmp++;
      if (got4() !== exp4()) begin
        n_err++; $display("FAIL pop %0d: got %h expected %h", i, got4(), exp4());
      end
    end
    drive4(0, 0, 0, 0, 2'd0);
    n_cmp++;
    if (got4() !== exp4()) begin
      n_err++; $display("FAIL udf_drop: got %h expected %h", got4(), exp4());
    end
  endtask

  task automatic test_replace();
    // {push, pop, din}: build count 2 top 2, replace, flush, push+pop on
    // empty, fill, then replace at full.
    logic [4:0] seq [10] = '{
      {1'b1, 1'b0, 1'b0, 2'd1}, {1'b1, 1'b0, 1'b0, 2'd2}, {1'b1, 1'b1, 1'b0, 2'd3},
      {1'b0, 1'b0, 1'b1, 2'd0}, {1'b1, 1'b1, 1'b0, 2'd1}, {1'b1, 1'b0, 1'b0, 2'd2},
      {1'b1, 1'b0, 1'b0, 2'd3}, {1'b1, 1'b0, 1'b0, 2'd0}, {1'b1, 1'b1, 1'b0, 2'd2},
      {1'b1, 1'b1, 1'b0, 2'd1}};
    drive4(1, 0, 0, 0, 2'd0);
    for (int i = 0; i < 10; i++) begin
      drive4(0, seq[i][4], seq[i][3], seq[i][2], seq[i][1:0]);
      n_cmp++;
      if (got4() !== exp4()) begin
        n_err++; $display("FAIL replace %0d: got %h expected %h", i, got4(), exp4());
      end
    end
  endtask

  task automatic test_flush();
    drive4(1, 0, 0, 0, 2'd0);
    for (int i = 0; i < 3; i++) drive4(0, 1, 0, 0, 2'(i + 1));
    drive4(0, 1, 0, 1, 2'd3);  // flush beats push, no ovf
    n_cmp++;
    if (got4() !== 9'b000_00_0100) begin
      n_err++; $display("FAIL flush: got %h expected %h", got4(), 9'b000_00_0100);
    end
    drive4(0, 1, 0, 0, 2'd2);
    n_cmp++;
    if (got4() !== 9'b001_10_0000) begin
      n_err++; $display("FAIL post_flush_push: got %h expected %h", got4(), 9'b001_10_0000);
    end
  endtask

  task automatic test_depth5();
    drive5(1, 0, 0, 0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      drive5(0, 1, 0, 0, 8'($urandom));
      n_cmp++;
      if (got5() !== exp5()) begin
        n_err++; $display("FAIL d5 push %0d: got %h expected %h", i, got5(), exp5());
      end
    end
    drive5(1, 1, 0, 0, 8'h3C);
    n_cmp++;
    if (got5() !== 15'b000_00000000_0100) begin
      n_err++; $display("FAIL d5 rst_push: got %h expected %h", got5(), 15'b000_00000000_0100);
    end
    drive5(0, 1, 0, 0, 8'hA5);
    n_cmp++;
    if (got5() !== {3'd1, 8'hA5, 4'b0000}) begin
      n_err++; $display("FAIL d5 push_a5: got %h expected %h", got5(), {3'd1, 8'hA5, 4'b0000});
    end
  endtask

  task automatic test_random();
    logic r, p, q, f;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 63) == 0);
      f = ($urandom_range(0, 23) == 0);
      p = ($urandom_range(0, 99) < 55);
      q = ($urandom_range(0, 99) < 45);
      drive4(r, p, q, f, 2'($urandom));
      n_cmp++;
      if (got4() !== exp4()) begin
        n_err++; $display("FAIL rand4 %0d: got %h expected %h", i, got4(), exp4());
      end
      r = ($urandom_range(0, 63) == 0);
      f = ($urandom_range(0, 23) == 0);
      p = ($urandom_range(0, 99) < 55);
      q = ($urandom_range(0, 99) < 45);
      drive5(r, p, q, f, 8'($urandom));
      n_cmp++;
      if (got5() !== exp5()) begin
        n_err++; $display("FAIL rand5 %0d: got %h expected %h", i, got5(), exp5());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    b4.push = 1'b0; b4.pop = 1'b0; b4.flush = 1'b0; b4.din = '0;
    b5.push = 1'b0; b5.pop = 1'b0; b5.flush = 1'b0; b5.din = '0;
    test_reset();
    test_push_pop();
    test_replace();
    test_flush();
    test_depth5();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised LIFO stack; next generation of the fixed 2-bit, 256-entry stack.
- Generalised in data width and depth.
- Adds:
  - simultaneous push+pop as a replace-top operation
  - a flush input
  - an occupancy count
  - one-cycle overflow/underflow error pulses
- Used as operand/return-address storage by datapath and controller blocks. Exactly one stack operation per clock.

Parameters:
- WIDTH, 2, data bits per entry (>=1)
- DEPTH, 256, number of entries (>=2; need not be a power of two)
- CW, $clog2(DEPTH+1), derived count width; not overridable

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- push  in  1  write din onto stack
- pop  in  1  remove top entry
- flush  in  1  discard all entries
- din  in  WIDTH  data to push / replace
- top  out  WIDTH  current top-of-stack; 0 when empty
- count  out  CW  number of valid entries, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- ovf  out  1  one-cycle pulse: push refused because full
- udf  out  1  one-cycle pulse: pop refused because empty

Behaviour:
- Single clock domain. All state changes on rising clk.
- rst is sampled only at a clock edge and has priority over every other input.
- Reset values:
  - count=0, empty=1, full=0, ovf=0, udf=0, top=0
  - Memory contents are not reset.
- State: storage array mem[0..DEPTH-1] and pointer count. Entry count-1 is the top.
- Outputs full, empty and top are combinational decodes of the registered count and mem:
  - top = mem[count-1] when count>0, else 0. top is never X.
  - Zero latency: an operation at edge N is visible on top/count/full/empty immediately after edge N.
- ovf and udf are registered. Each is high for exactly the cycle after the refused operation, otherwise 0.
- Operation priority per edge (rst=0):
  1. flush=1: count<=0. push/pop ignored. No error pulses.
  2. push=1, pop=1, count>0: replace. mem[count-1]<=din; count unchanged. Full or not, no error.
  3. push=1, pop=1, count==0: treated as push of din. count<=1.
  4. push=1, count<DEPTH: mem[count]<=din; count<=count+1.
  5. push=1, count==DEPTH: no state change; ovf<=1.
  6. pop=1, count>0: count<=count-1. The popped value is not cleared.
  7. pop=1, count==0: no state change; udf<=1.
  8. none asserted: hold.
- Boundaries:
  - count never wraps. It saturates at DEPTH and at 0 by refusal, not by modular arithmetic.
  - Pushing from DEPTH-1 sets full on the same edge.
  - Popping from 1 sets empty and forces top=0 on the same edge.
  - DEPTH not a power of two: count compares exactly against DEPTH. No address beyond DEPTH-1 is ever written.
  - rst or flush mid-sequence abandons all entries. The next push lands at mem[0].

Decomposition:
- Shared package stack_pkg holds:
  - enum stack_op_e {OP_NOP, OP_PUSH, OP_POP, OP_REPLACE, OP_FLUSH}, decoded once from push/pop/flush/count
  - localparam function for CW
  - a status struct {full, empty, ovf, udf} for controllers that bundle flags
- One natural sub-module: stack_mem, a WIDTH x DEPTH array with a single synchronous write port and one asynchronous read port. param_stack holds the pointer, operation decode and flags.

Test Plan:
- Reset, then idle 3 cycles -> count=0, empty=1, full=0, top=0, ovf=udf=0 throughout.
- WIDTH=2, DEPTH=4: push 1,2,3,0 -> count 1..4, top follows each value, full=1 after 4th edge; 5th push of 3 -> ovf=1 for one cycle, count=4, top=0.
- From full: pop x4 -> top 3,2,1 then 0, empty=1 after 4th pop; 5th pop -> udf=1 one cycle, count=0.
- count=2 with top=2: push=1,pop=1,din=3 -> top=3, count=2. On empty stack push+pop din=1 -> count=1, top=1. At full, replace -> no ovf.
- count=3: assert flush with push=1 -> count=0, empty=1, no ovf. Next push 2 -> count=1, top=2.
- DEPTH=5 (non-power-of-two), WIDTH=8: push 5 values then a 6th -> ovf, full=1. Assert rst with push=1 -> count=0, no write; after release, push 0xA5 -> top=0xA5.
